obi_prefetch_buffer: RTL and testbench

Instruction-fetch front end that sits directly upstream of the OBI boot ROM and instruction memories. It generates sequential word fetches as an OBI master, buffers returned words with their addresses in a small FIFO, and presents them to the core through a valid/ready interface. On a redirect (branch, jump, or exception), it flushes and discards in-flight responses.

---
 rtl/obi_pkg.sv | 14 +
 rtl/prefetch_fifo.sv | 64 ++++++
 rtl/obi_prefetch_buffer.sv | 132 +++++++++++++
 tb/tb_obi_prefetch_buffer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_pkg.sv
// Shared OBI fetch-path widths, boot address and the buffered fetch entry type.
package obi_pkg;

  localparam int unsigned OBI_AW = 32;
  localparam int unsigned OBI_DW = 32;

  localparam logic [OBI_AW-1:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [OBI_AW-1:0] addr;
    logic [OBI_DW-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted when a pop happens alongside.
module prefetch_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Flush takes priority over both push and pop.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/obi_prefetch_buffer.sv
// Sequential OBI instruction prefetcher: issues word fetches, buffers {addr, data} for the core and
// discards responses that were in flight when a redirect arrived.
module obi_prefetch_buffer
  import obi_pkg::*;
#(
  parameter int unsigned       DEPTH     = 4,
  parameter logic [OBI_AW-1:0] BOOT_ADDR = BOOT_ADDR_DEFAULT,
  parameter int unsigned       MAX_OUTST = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o,
  output logic        req_o,
  input  logic        gnt_i,
  output logic [31:0] addr_o,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned OstW = $clog2(MAX_OUTST + 1);
  localparam int unsigned DisW = $clog2(MAX_OUTST + 2);

  logic [OBI_AW-1:0] fptr_q, fptr_d, hold_addr_q, hold_addr_d, resp_addr;
  logic              hold_q, hold_d, stale_q, stale_d;
  logic [DisW-1:0]   discard_q, discard_d, outst_next;
  logic [OstW-1:0]   outst;
  logic [CntW-1:0]   count;
  logic              issue_ok, grant, resp;
  logic              addr_full, addr_empty, data_full, data_empty, data_push, data_pop;
  fetch_entry_t      head, push_entry;

  // The address FIFO occupancy is the outstanding-transaction count.
  assign grant = req_o & gnt_i;
  assign resp  = rvalid_i & ~addr_empty;

  // Reserve a buffer slot for every live outstanding request; discarded ones need none.
  always_comb begin
    issue_ok = fetch_en_i && !addr_full &&
               ((32'(count) + 32'(outst)) < (DEPTH + 32'(discard_q)));
  end

  assign req_o  = hold_q | issue_ok;
  assign addr_o = hold_q ? hold_addr_q : fptr_q;

  assign data_push  = resp & (discard_q == '0) & ~branch_i;
  assign data_pop   = instr_valid_o & instr_ready_i;
  assign push_entry = '{addr: resp_addr, data: rdata_i};

  always_comb begin
    fptr_d      = fptr_q;
    discard_d   = discard_q;
    hold_d      = req_o & ~gnt_i;
    hold_addr_d = addr_o;
    // A request held across a redirect still belongs to the old stream.
    stale_d     = hold_d & (stale_q | branch_i);
    outst_next  = DisW'(outst) + DisW'(grant) - DisW'(resp);

    if (grant && !(hold_q && stale_q)) fptr_d = fptr_q + 32'd4;
    if (resp && discard_q != '0) discard_d = discard_q - 1'b1;

    if (branch_i) begin
      fptr_d    = {branch_addr_i[31:2], 2'b00};
      discard_d = outst_next + DisW'(hold_d);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fptr_q      <= BOOT_ADDR;
      hold_addr_q <= BOOT_ADDR;
      hold_q      <= 1'b0;
      stale_q     <= 1'b0;
      discard_q   <= '0;
    end else begin
      fptr_q      <= fptr_d;
      hold_addr_q <= hold_addr_d;
      hold_q      <= hold_d;
      stale_q     <= stale_d;
      discard_q   <= discard_d;
    end
  end

  prefetch_fifo #(
    .Depth (MAX_OUTST),
    .Width (OBI_AW)
  ) u_addr_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .push_i  (grant),
    .data_i  (addr_o),
    .pop_i   (resp),
    .data_o  (resp_addr),
    .full_o  (addr_full),
    .empty_o (addr_empty),
    .count_o (outst)
  );

  prefetch_fifo #(
    .Depth (DEPTH),
    .Width ($bits(fetch_entry_t))
  ) u_data_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (branch_i),
    .push_i  (data_push),
    .data_i  (push_entry),
    .pop_i   (data_pop),
    .data_o  (head),
    .full_o  (data_full),
    .empty_o (data_empty),
    .count_o (count)
  );

  assign instr_valid_o = ~data_empty;
  assign instr_rdata_o = head.data;
  assign instr_addr_o  = head.addr;

  rvalid_without_request: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rvalid_i && addr_empty));

  data_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(data_push && data_full && !data_pop));

endmodule

// File: tb/tb_obi_prefetch_buffer.sv
// Bench for obi_prefetch_buffer: OBI slave model plus a stream-level scoreboard of fetch order.
module tb_obi_prefetch_buffer;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_OUTST = 2;
  localparam logic [31:0] BOOT      = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        fetch_en_i, branch_i, instr_ready_i, gnt_i, rvalid_i;
  logic [31:0] branch_addr_i, rdata_i;
  logic        instr_valid_o, req_o;
  logic [31:0] instr_rdata_o, instr_addr_o, addr_o;

  always #5 clk_i = ~clk_i;

  obi_prefetch_buffer #(
    .DEPTH     (DEPTH),
    .BOOT_ADDR (BOOT),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .fetch_en_i    (fetch_en_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_rdata_o (instr_rdata_o),
    .instr_addr_o  (instr_addr_o),
    .req_o         (req_o),
    .gnt_i         (gnt_i),
    .addr_o        (addr_o),
    .rvalid_i      (rvalid_i),
    .rdata_i       (rdata_i)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference state: next address the stream should fetch and deliver, slave pending queue.
  logic [31:0] exp_fetch, exp_del, prev_addr;
  logic [31:0] resp_q[$];
  logic [31:0] grant_log[$];
  logic [31:0] deliv_log[$];
  logic        prev_held, held_stale;
  int          cyc, n_grant, n_deliv, first_grant_cyc, first_deliv_cyc;
  int unsigned gnt_pct, rv_pct;

  function automatic logic [31:0] grant_at(input int i);
    return (i < grant_log.size()) ? grant_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] deliv_at(input int i);
    return (i < deliv_log.size()) ? deliv_log[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic drive_slave();
    gnt_i    = ($urandom_range(99) < gnt_pct);
    rvalid_i = (resp_q.size() > 0) && ($urandom_range(99) < rv_pct);
    rdata_i  = rvalid_i ? mem_word(resp_q[0]) : $urandom();
  endtask

  task automatic observe();
    if (prev_held) begin
      check_val("hold_req", 32'(req_o), 32'd1);
      check_val("hold_addr", addr_o, prev_addr);
    end
    if (rvalid_i) void'(resp_q.pop_front());
    if (req_o && gnt_i) begin
      if (!(prev_held && held_stale)) begin
        check_val("fetch_addr", addr_o, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
      resp_q.push_back(addr_o);
      grant_log.push_back(addr_o);
      check_val("outst_max", 32'(resp_q.size() <= MAX_OUTST), 32'd1);
      if (first_grant_cyc < 0) first_grant_cyc = cyc;
      n_grant++;
    end
    if (req_o && !gnt_i) begin
      held_stale = (prev_held ? held_stale : 1'b0) | branch_i;
      prev_held  = 1'b1;
      prev_addr  = addr_o;
    end else begin
      prev_held  = 1'b0;
      held_stale = 1'b0;
    end
    if (instr_valid_o && instr_ready_i && !branch_i) begin
      check_val("deliv_addr", instr_addr_o, exp_del);
      check_val("deliv_data", instr_rdata_o, mem_word(exp_del));
      deliv_log.push_back(instr_addr_o);
      if (first_deliv_cyc < 0) first_deliv_cyc = cyc;
      exp_del = exp_del + 32'd4;
      n_deliv++;
    end
    if (branch_i) begin
      exp_fetch = {branch_addr_i[31:2], 2'b00};
      exp_del   = {branch_addr_i[31:2], 2'b00};
    end
  endtask

  task automatic tick();
    drive_slave();
    @(negedge clk_i);
    observe();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic tick_branch(input logic [31:0] target);
    branch_addr_i = target;
    branch_i      = 1'b1;
    tick();
    branch_i      = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check_val({pfx, "_req"}, 32'(req_o), 32'd0);
    check_val({pfx, "_addr_o"}, addr_o, BOOT);
    check_val({pfx, "_valid"}, 32'(instr_valid_o), 32'd0);
    check_val({pfx, "_rdata"}, instr_rdata_o, 32'd0);
    check_val({pfx, "_iaddr"}, instr_addr_o, 32'd0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    fetch_en_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
    gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; instr_ready_i = 1'b0;
    resp_q.delete(); grant_log.delete(); deliv_log.delete();
    exp_fetch = BOOT; exp_del = BOOT; prev_addr = BOOT;
    prev_held = 1'b0; held_stale = 1'b0;
    cyc = 0; n_grant = 0; n_deliv = 0; first_grant_cyc = -1; first_deliv_cyc = -1;
    gnt_pct = 100; rv_pct = 100;
    repeat (2) @(posedge clk_i);
    #1 check_reset_vals("rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int snap;

    // Straight-line fetch: latency and throughput.
    do_reset();
    fetch_en_i = 1'b1; instr_ready_i = 1'b1;
    repeat (16) tick();
    check_val("first_latency", 32'(first_deliv_cyc - first_grant_cyc), 32'd2);
    check_val("first_iaddr", deliv_at(0), BOOT);
    check_val("grants_16", 32'(n_grant), 32'd16);
    check_val("one_per_cycle", 32'(n_deliv), 32'(16 - first_deliv_cyc));

    // Stalled core: reservations stop fetching at DEPTH.
    do_reset();
    fetch_en_i = 1'b1; instr_ready_i = 1'b0;
    repeat (12) tick();
    check_val("stall_grants", 32'(n_grant), 32'(DEPTH));
    check_val("stall_req_low", 32'(req_o), 32'd0);
    check_val("stall_valid", 32'(instr_valid_o), 32'd1);
    instr_ready_i = 1'b1;
    repeat (8) tick();
    check_val("stall_drain", 32'(n_deliv >= 4), 32'd1);

    // Redirect with two responses in flight.
    do_reset();
    fetch_en_i = 1'b1; instr_ready_i = 1'b1; rv_pct = 0;
    repeat (4) tick();
    check_val("outst2_grants", 32'(n_grant), 32'd2);
    check_val("outst2_req_low", 32'(req_o), 32'd0);
    tick_branch(32'h0000_0100);
    rv_pct = 100;
    repeat (10) tick();
    check_val("br100_first", deliv_at(0), 32'h0000_0100);
    check_val("br100_second", deliv_at(1), 32'h0000_0104);

    // Redirect while a request is held ungranted.
    do_reset();
    fetch_en_i = 1'b1; instr_ready_i = 1'b1; gnt_pct = 0;
    tick();
    tick_branch(32'h0000_0202);
    fetch_en_i = 1'b0;
    tick();
    fetch_en_i = 1'b1; gnt_pct = 100;
    repeat (10) tick();
    check_val("held_old_addr", grant_at(0), 32'h0000_0000);
    check_val("held_then_target", grant_at(1), 32'h0000_0200);
    check_val("br200_first", deliv_at(0), 32'h0000_0200);

    // Redirect coincident with a pop and a response.
    do_reset();
    fetch_en_i = 1'b1; instr_ready_i = 1'b1;
    repeat (6) tick();
    check_val("pre_flush_valid", 32'(instr_valid_o), 32'd1);
    deliv_log.delete();
    tick_branch(32'h0000_0300);
    check_val("flush_empty", 32'(instr_valid_o), 32'd0);
    repeat (10) tick();
    check_val("br300_first", deliv_at(0), 32'h0000_0300);

    // Fetch pointer wrap, then asynchronous reset mid-stream.
    do_reset();
    fetch_en_i = 1'b1; instr_ready_i = 1'b1;
    tick_branch(32'hFFFF_FFFC);
    grant_log.delete(); deliv_log.delete();
    repeat (8) tick();
    check_val("wrap_grant0", grant_at(0), 32'hFFFF_FFFC);
    check_val("wrap_grant1", grant_at(1), 32'h0000_0000);
    check_val("wrap_deliv1", deliv_at(1), 32'h0000_0000);
    check_val("pre_rst_valid", 32'(instr_valid_o), 32'd1);
    #2;
    rst_ni = 1'b0; fetch_en_i = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b0;
    #1 check_reset_vals("midrst");
    do_reset();

    // Randomized traffic against the stream model.
    for (int blk = 0; blk < 8; blk++) begin
      gnt_pct = $urandom_range(100, 20);
      rv_pct  = $urandom_range(100, 20);
      for (int i = 0; i < 500; i++) begin
        fetch_en_i    = ($urandom_range(9) != 0);
        instr_ready_i = ($urandom_range(9) < 7);
        if ($urandom_range(99) < 4) begin
          tick_branch($urandom());
        end else begin
          tick();
        end
      end
    end
    fetch_en_i = 1'b1; instr_ready_i = 1'b1; gnt_pct = 100; rv_pct = 100;
    snap = n_deliv;
    repeat (50) tick();
    check_val("drain_progress", 32'((n_deliv - snap) >= 20), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
